spi_slave_responder: RTL and testbench

- SPI mode-0 slave (CPOL=0, CPHA=0), MSB first. It is the responder that drives the processor's miso_pi line.
- It oversamples the master's SCLK/CS_N/MOSI in the processor clock domain, shifts out words supplied by the local side on MISO, and returns each received MOSI word with a one-cycle valid pulse.
- It is used as the far-end device model and as the on-board peripheral answering the multicycle processor's SPI master.

---
 rtl/spi_slave_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// Purpose : SPI mode-0 (CPOL=0, CPHA=0) MSB-first slave; drives MISO from a one-entry TX holding register, returns each received MOSI word.
// Latency : rx_valid_po pulses SYNC_STAGES+2 clk_pi cycles after the final SCLK rising edge at the pin; MISO follows an SCLK fall within SYNC_STAGES+1 cycles.
// Backpres: tx_ready_po low while the holding register is full (tx_valid_pi ignored then); RX side has no backpressure, rx_data_po is simply overwritten.
// Optional: define SPI_SLV_OVERRUN_EN to add rx_ack_pi / rx_overrun_po overrun tracking.
module spi_slave_responder #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE     = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk_pi,
  input  logic                  rst_pi,
  input  logic                  sclk_pi,
  input  logic                  cs_n_pi,
  input  logic                  mosi_pi,
  output logic                  miso_po,
  input  logic [DATA_WIDTH-1:0] tx_data_pi,
  input  logic                  tx_valid_pi,
  output logic                  tx_ready_po,
  output logic [DATA_WIDTH-1:0] rx_data_po,
  output logic                  rx_valid_po,
`ifdef SPI_SLV_OVERRUN_EN
  input  logic                  rx_ack_pi,
  output logic                  rx_overrun_po,
`endif
  output logic                  busy_po
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains and edge-detect delay flops
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_n_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   cs_n_dly_q;

  logic sclk_s;
  logic cs_n_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  // Frame state
  state_t                state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q,     hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic                  rx_done_q,  rx_done_d;
  logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q,     miso_d;

  logic                  tx_load;
  logic                  tx_wr;
  logic [DATA_WIDTH-1:0] load_word;

  // Bring the asynchronous SPI pins into clk_pi; presets match an idle bus (CS high, SCLK low)
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      sclk_sync_q <= '0;
      cs_n_sync_q <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_n_dly_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_pi};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], cs_n_pi};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_pi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_n_dly_q  <= cs_n_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s &  sclk_dly_q;
  assign cs_fall   = ~cs_n_s &  cs_n_dly_q;
  assign cs_rise   =  cs_n_s & ~cs_n_dly_q;

  // A frame load takes whatever the holding register had before this cycle's write
  assign load_word = hold_vld_q ? hold_q : TX_IDLE;
  assign tx_wr     = tx_valid_pi & ~hold_vld_q;

  // State, shift and holding-register registers
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      rx_done_q  <= rx_done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
    end
  end

  // Frame FSM: CS edges frame the transfer, SCLK rise samples MOSI, SCLK fall advances MISO
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    rx_done_d  = 1'b0;
    tx_load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          tx_load = 1'b1;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        // CS release beats any SCLK edge seen in the same cycle
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            rx_done_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (cnt_q == CNT_W'(DATA_WIDTH)) begin
            // Back-to-back frame: next word starts on this fall
            tx_load = 1'b1;
            cnt_d   = '0;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (tx_load) begin
      tx_shift_d = load_word;
      hold_vld_d = 1'b0;
    end

    if (tx_wr) begin
      hold_d     = tx_data_pi;
      hold_vld_d = 1'b1;
    end

    miso_d     = (state_d == ACTIVE) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
    rx_valid_d = rx_done_q;
    rx_data_d  = rx_done_q ? rx_shift_q : rx_data_q;
  end

`ifdef SPI_SLV_OVERRUN_EN
  logic rx_pending_q, rx_pending_d;
  logic rx_overrun_q, rx_overrun_d;

  // Overrun flags: pending tracks an unacknowledged word, overrun is sticky until acked
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      rx_pending_q <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_pending_q <= rx_pending_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  // A completion while a word is still pending sets overrun; ack clears only in a quiet cycle
  always_comb begin
    rx_pending_d = rx_pending_q;
    rx_overrun_d = rx_overrun_q;
    if (rx_valid_q) begin
      rx_pending_d = 1'b1;
    end else if (rx_ack_pi) begin
      rx_pending_d = 1'b0;
    end
    if (rx_done_q && rx_pending_q) begin
      rx_overrun_d = 1'b1;
    end else if (rx_ack_pi && !rx_done_q) begin
      rx_overrun_d = 1'b0;
    end
  end

  assign rx_overrun_po = rx_overrun_q;
`endif

  assign miso_po     = miso_q;
  assign tx_ready_po = ~hold_vld_q;
  assign rx_data_po  = rx_data_q;
  assign rx_valid_po = rx_valid_q;
  assign busy_po     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a bit-banged SPI master at clk/10,
// a scoreboard queue of expected RX words checked on every rx_valid_po pulse,
// and direct checks of MISO words and status outputs.
module tb_spi_slave_responder;

  logic       clk_pi = 1'b0;
  logic       rst_pi;
  logic       sclk_pi;
  logic       cs_n_pi;
  logic       mosi_pi;
  logic       miso_po;
  logic [7:0] tx_data_pi;
  logic       tx_valid_pi;
  logic       tx_ready_po;
  logic [7:0] rx_data_po;
  logic       rx_valid_po;
  logic       busy_po;
`ifdef SPI_SLV_OVERRUN_EN
  logic       rx_ack_pi;
  logic       rx_overrun_po;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rise_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mi;

  always #5 clk_pi = ~clk_pi;

  spi_slave_responder #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .TX_IDLE    (8'hFF)
  ) dut (
    .clk_pi      (clk_pi),
    .rst_pi      (rst_pi),
    .sclk_pi     (sclk_pi),
    .cs_n_pi     (cs_n_pi),
    .mosi_pi     (mosi_pi),
    .miso_po     (miso_po),
    .tx_data_pi  (tx_data_pi),
    .tx_valid_pi (tx_valid_pi),
    .tx_ready_po (tx_ready_po),
    .rx_data_po  (rx_data_po),
    .rx_valid_po (rx_valid_po),
`ifdef SPI_SLV_OVERRUN_EN
    .rx_ack_pi   (rx_ack_pi),
    .rx_overrun_po(rx_overrun_po),
`endif
    .busy_po     (busy_po)
  );

  always @(posedge clk_pi) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Every rx_valid_po pulse must match the oldest queued word and arrive 4 cycles after the last SCLK rise
  always @(posedge clk_pi) begin
    #1;
    if (rx_valid_po === 1'b1) begin
      chk("rx_pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      chk("rx_latency", cyc - rise_cyc, 32'd4);
      if (exp_q.size() > 0) begin
        chk("rx_data", {24'd0, rx_data_po}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk_pi);
    tx_data_pi  = d;
    tx_valid_pi = 1'b1;
    @(negedge clk_pi);
    tx_valid_pi = 1'b0;
  endtask

  task automatic cs_lo();
    @(negedge clk_pi);
    cs_n_pi = 1'b0;
    repeat (10) @(negedge clk_pi);
  endtask

  task automatic cs_hi();
    @(negedge clk_pi);
    cs_n_pi = 1'b1;
    repeat (10) @(negedge clk_pi);
  endtask

  // Mode-0 master: MOSI set while SCLK low, MISO captured at SCLK rise, half period = 5 clk
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi_o);
    mi_o = '0;
    if (nbits == 8) exp_q.push_back(mo);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk_pi);
      mosi_pi = mo[i];
      repeat (4) @(negedge clk_pi);
      sclk_pi  = 1'b1;
      mi_o[i]  = miso_po;
      rise_cyc = cyc;
      repeat (5) @(negedge clk_pi);
      sclk_pi = 1'b0;
    end
  endtask

  initial begin
    rst_pi      = 1'b1;
    sclk_pi     = 1'b0;
    cs_n_pi     = 1'b1;
    mosi_pi     = 1'b0;
    tx_data_pi  = '0;
    tx_valid_pi = 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
    rx_ack_pi   = 1'b0;
`endif

    // Reset values
    repeat (3) @(negedge clk_pi);
    chk("rst_miso", {31'd0, miso_po}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready_po}, 32'd1);
    chk("rst_rx_valid", {31'd0, rx_valid_po}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data_po}, 32'h00);
    chk("rst_busy", {31'd0, busy_po}, 32'd0);
`ifdef SPI_SLV_OVERRUN_EN
    chk("rst_overrun", {31'd0, rx_overrun_po}, 32'd0);
`endif
    rst_pi = 1'b0;
    repeat (3) @(negedge clk_pi);

    // Single frame
    tx_write(8'hA5);
    chk("wr_tx_ready_low", {31'd0, tx_ready_po}, 32'd0);
    cs_lo();
    chk("single_tx_ready", {31'd0, tx_ready_po}, 32'd1);
    chk("single_busy", {31'd0, busy_po}, 32'd1);
    xfer(8'h3C, 8, mi);
    chk("single_miso", {24'd0, mi}, 32'hA5);
    cs_hi();
    chk("single_idle_busy", {31'd0, busy_po}, 32'd0);
    chk("single_idle_miso", {31'd0, miso_po}, 32'd0);

    // Empty holding register shifts TX_IDLE
    cs_lo();
    xfer(8'h00, 8, mi);
    chk("empty_miso", {24'd0, mi}, 32'hFF);
    cs_hi();

    // Back-to-back frames with CS held low
    tx_write(8'h12);
    cs_lo();
    chk("b2b_ready_after_load", {31'd0, tx_ready_po}, 32'd1);
    tx_write(8'h34);
    chk("b2b_ready_full", {31'd0, tx_ready_po}, 32'd0);
    xfer(8'hC3, 8, mi);
    chk("b2b_miso0", {24'd0, mi}, 32'h12);
    xfer(8'h5A, 8, mi);
    chk("b2b_miso1", {24'd0, mi}, 32'h34);
    cs_hi();
    chk("b2b_rx_last", {24'd0, rx_data_po}, 32'h5A);

    // Aborted frame after 5 SCLKs leaves rx_data_po alone
    cs_lo();
    xfer(8'hF0, 5, mi);
    cs_hi();
    chk("abort_rx_data", {24'd0, rx_data_po}, 32'h5A);
    chk("abort_busy", {31'd0, busy_po}, 32'd0);
    cs_lo();
    xfer(8'h81, 8, mi);
    cs_hi();
    chk("after_abort_rx", {24'd0, rx_data_po}, 32'h81);

    // Reset mid-frame with a buffered TX word
    cs_lo();
    tx_write(8'h77);
    chk("mid_ready_full", {31'd0, tx_ready_po}, 32'd0);
    xfer(8'hAA, 3, mi);
    @(negedge clk_pi);
    rst_pi  = 1'b1;
    cs_n_pi = 1'b1;
    repeat (2) @(negedge clk_pi);
    chk("mid_rst_miso", {31'd0, miso_po}, 32'd0);
    chk("mid_rst_tx_ready", {31'd0, tx_ready_po}, 32'd1);
    chk("mid_rst_rx_valid", {31'd0, rx_valid_po}, 32'd0);
    chk("mid_rst_rx_data", {24'd0, rx_data_po}, 32'h00);
    chk("mid_rst_busy", {31'd0, busy_po}, 32'd0);
    rst_pi = 1'b0;
    repeat (5) @(negedge clk_pi);
    cs_lo();
    xfer(8'h11, 8, mi);
    chk("post_rst_miso", {24'd0, mi}, 32'hFF);
    cs_hi();

`ifdef SPI_SLV_OVERRUN_EN
    chk("ovr_first_frame", {31'd0, rx_overrun_po}, 32'd0);
    cs_lo();
    xfer(8'h22, 8, mi);
    cs_hi();
    chk("ovr_second_frame", {31'd0, rx_overrun_po}, 32'd1);
    @(negedge clk_pi);
    rx_ack_pi = 1'b1;
    @(negedge clk_pi);
    rx_ack_pi = 1'b0;
    chk("ovr_ack_clear", {31'd0, rx_overrun_po}, 32'd0);
`endif

    repeat (10) @(negedge clk_pi);
    chk("rx_all_pulses_seen", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
